sad_top: RTL and testbench
==========================

// Module: sad_top
// PURPOSE
//  Sum-of-Absolute-Differences engine for one 16x16 block of 8-bit pixels.
//  Two independent write-side FIFOs are filled with the current block (stream 1)
//  and the reference block (stream 2). An internal read controller pops pixel pairs
//  and accumulates |p1-p2| into a 32-bit SAD register. Sits between the pixel
//  loaders and the motion-estimation decision logic.
// PARAMETERS
//  DATA_W   8    pixel width
//  DEPTH    256  entries per FIFO (power of two)
//  CNT_W    9    FIFO occupancy / pair-index width, $clog2(DEPTH)+1
//  NPIX     256  pixel pairs per block (16x16)
//  SAD_W    32   accumulator width
// PORTS
//  clk          in   1       clock; all state changes on rising edge
//  rst          in   1       asynchronous active-low reset
//  data_in1     in   8       stream-1 pixel, sampled when wr1=1
//  data_in2     in   8       stream-2 pixel, sampled when wr2=1
//  wr1          in   1       write strobe, FIFO 1
//  wr2          in   1       write strobe, FIFO 2
//  empty1       out  1       FIFO 1 count==0
//  full1        out  1       FIFO 1 count==DEPTH
//  empty2       out  1       FIFO 2 count==0
//  full2        out  1       FIFO 2 count==DEPTH
//  FIFO_count1  out  9       FIFO 1 occupancy, 0..256
//  FIFO_count2  out  9       FIFO 2 occupancy, 0..256
//  data_out1    out  8       last pixel popped from FIFO 1 (registered)
//  data_out2    out  8       last pixel popped from FIFO 2 (registered)
//  sad_reg      out  32      running/final SAD
//  i            out  9       pixel pairs accumulated so far, 0..256
// BEHAVIOUR
//  - Reset (rst=0, async): pointers, counts, data_out1/2, sad_reg, i, valid flag
//    cleared to 0; empty1/2=1, full1/2=0. FIFO RAM contents need not be cleared.
//  - Write: wrN && !fullN -> store data_inN at write pointer, pointer +1 mod DEPTH.
//    Write while full is dropped; count and contents unchanged.
//  - Read controller: rd = !empty1 && !empty2 && (i + inflight < NPIX). rd pops
//    both FIFOs in the same cycle; one pair per cycle max. Never reads empty FIFO.
//  - Simultaneous write+read on one FIFO: both performed, count unchanged
//    (legal even when full or empty because read requires non-empty, write
//    uses pre-edge full).
//  - Counts: +1 on write-only, -1 on read-only; flags combinational from count.
//  - Pipeline: edge after rd -> data_out1/2 <= popped pixels, valid <= 1.
//    Next edge with valid=1 -> sad_reg <= sad_reg + |data_out1-data_out2|
//    (9-bit unsigned difference, zero-extended), i <= i+1. Latency rd->sad 2 clk.
//  - Block completion: when i reaches NPIX (256) the controller stops reading;
//    sad_reg and i hold. Max SAD = 256*255 = 65280 (no overflow in 32 bits).
//    Data left in FIFOs stays until reset. New block requires reset.
//  - Reset mid-operation clears all state immediately; partial SAD discarded.
// TESTING
//  1 Reset: rst=0 -> empties=1, fulls=0, counts=0, sad_reg=0, i=0, data_out=0.
//  2 Identical blocks: 256 equal pairs written one per clk on both wr -> i=256,
//    sad_reg=0, both FIFOs empty.
//  3 Max diff: stream1 all 8'hFF, stream2 all 8'h00 -> sad_reg=65280 (0xFF00), i=256.
//  4 Ramp: stream1 = k (k=0..255), stream2 = 0 -> sad_reg=32640; swap streams -> same.
//  5 Full: write 257 pixels to FIFO1 only -> no reads, FIFO_count1=256, full1=1,
//    257th dropped; then 256 writes to FIFO2 -> sad of first 256 pairs, i=256.
//  6 Mid reset: assert rst after 100 pairs -> all outputs back to reset values
//    async; restart with case 3 data -> 65280.

Source files
------------

// File: rtl/sad_top.sv
// Sum-of-absolute-differences engine: two pixel FIFOs feed a pop/accumulate
// pipeline that sums |p1-p2| over one 16x16 block.

module sad_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;

  // A write while full is dropped; the reader never pops an empty FIFO.
  assign w_wr    = i_wr && !o_full;
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, i_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module sad_top #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9,
  parameter int NPIX   = 256,
  parameter int SAD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic              wr1,
  input  logic              wr2,
  output logic              empty1,
  output logic              full1,
  output logic              empty2,
  output logic              full2,
  output logic [CNT_W-1:0]  FIFO_count1,
  output logic [CNT_W-1:0]  FIFO_count2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [SAD_W-1:0]  sad_reg,
  output logic [CNT_W-1:0]  i
);
  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d;
  endfunction

  logic [DATA_W-1:0] w_head1;
  logic [DATA_W-1:0] w_head2;
  logic              w_rd;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic              r_valid;
  logic [SAD_W-1:0]  r_sad;
  logic [CNT_W-1:0]  r_i;

  sad_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst),
    .i_wr    (wr1),
    .i_rd    (w_rd),
    .i_data  (data_in1),
    .o_head  (w_head1),
    .o_count (FIFO_count1),
    .o_empty (empty1),
    .o_full  (full1)
  );

  sad_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo2 (
    .clk     (clk),
    .rst_n   (rst),
    .i_wr    (wr2),
    .i_rd    (w_rd),
    .i_data  (data_in2),
    .o_head  (w_head2),
    .o_count (FIFO_count2),
    .o_empty (empty2),
    .o_full  (full2)
  );

  // The pair still in the pipeline counts against the block budget so we never overshoot NPIX.
  assign w_rd = !empty1 && !empty2 &&
                ((({1'b0, r_i}) + (CNT_W + 1)'(r_valid)) < (CNT_W + 1)'(NPIX));

  // Pop stage then accumulate stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data1 <= {DATA_W{1'b0}};
      r_data2 <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
      r_sad   <= {SAD_W{1'b0}};
      r_i     <= {CNT_W{1'b0}};
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_data1 <= w_head1;
        r_data2 <= w_head2;
      end
      if (r_valid) begin
        r_sad <= r_sad + SAD_W'(abs_diff(r_data1, r_data2));
        r_i   <= r_i + CNT_W'(1);
      end
    end
  end

  assign data_out1 = r_data1;
  assign data_out2 = r_data2;
  assign sad_reg   = r_sad;
  assign i         = r_i;
endmodule

// File: tb/tb_sad_top.sv
// Directed bench for sad_top: block SAD results, FIFO full/empty boundaries,
// completion hold and asynchronous reset mid-block.

module tb_sad_top;
  logic        clk;
  logic        rst;
  logic [7:0]  data_in1;
  logic [7:0]  data_in2;
  logic        wr1;
  logic        wr2;
  logic        w_empty1;
  logic        w_full1;
  logic        w_empty2;
  logic        w_full2;
  logic [8:0]  w_count1;
  logic [8:0]  w_count2;
  logic [7:0]  w_dout1;
  logic [7:0]  w_dout2;
  logic [31:0] w_sad;
  logic [8:0]  w_i;

  int n_vec;
  int n_err;

  sad_top dut (
    .clk         (clk),
    .rst         (rst),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .wr1         (wr1),
    .wr2         (wr2),
    .empty1      (w_empty1),
    .full1       (w_full1),
    .empty2      (w_empty2),
    .full2       (w_full2),
    .FIFO_count1 (w_count1),
    .FIFO_count2 (w_count2),
    .data_out1   (w_dout1),
    .data_out2   (w_dout2),
    .sad_reg     (w_sad),
    .i           (w_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic w1, input logic w2);
    @(negedge clk);
    data_in1 = a;
    data_in2 = b;
    wr1 = w1;
    wr2 = w2;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      wr1 = 1'b0;
      wr2 = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_empty1"}, 32'(w_empty1), 32'd1);
    check_val({tag, "_empty2"}, 32'(w_empty2), 32'd1);
    check_val({tag, "_full1"},  32'(w_full1),  32'd0);
    check_val({tag, "_full2"},  32'(w_full2),  32'd0);
    check_val({tag, "_cnt1"},   32'(w_count1), 32'd0);
    check_val({tag, "_cnt2"},   32'(w_count2), 32'd0);
    check_val({tag, "_dout1"},  32'(w_dout1),  32'd0);
    check_val({tag, "_dout2"},  32'(w_dout2),  32'd0);
    check_val({tag, "_sad"},    w_sad,         32'd0);
    check_val({tag, "_i"},      32'(w_i),      32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    wr1 = 1'b0;
    wr2 = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_state(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_count(input string tag, input int target);
    int c;
    c = 0;
    while ((32'(w_i) != target) && (c < 2000)) begin
      @(negedge clk);
      c++;
    end
    check_val({tag, "_reach"}, 32'(w_i), 32'(target));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    wr1 = 1'b0;
    wr2 = 1'b0;
    data_in1 = 8'h00;
    data_in2 = 8'h00;
    #12;
    check_reset_state("por");
    rst = 1'b1;

    // identical blocks
    for (int k = 0; k < 256; k++) begin
      drive(8'((k * 37) & 255), 8'((k * 37) & 255), 1'b1, 1'b1);
    end
    idle(1);
    wait_count("ident", 256);
    idle(3);
    check_val("ident_sad", w_sad, 32'd0);
    check_val("ident_empty1", 32'(w_empty1), 32'd1);
    check_val("ident_empty2", 32'(w_empty2), 32'd1);
    check_val("ident_dout1", 32'(w_dout1), 32'd219);
    check_val("ident_dout2", 32'(w_dout2), 32'd219);

    // maximum difference, then one extra pair after completion
    do_reset("rst2");
    for (int k = 0; k < 256; k++) begin
      drive(8'hFF, 8'h00, 1'b1, 1'b1);
    end
    idle(1);
    wait_count("max", 256);
    idle(3);
    check_val("max_sad", w_sad, 32'd65280);
    check_val("max_dout1", 32'(w_dout1), 32'd255);
    check_val("max_dout2", 32'(w_dout2), 32'd0);
    drive(8'h12, 8'h34, 1'b1, 1'b1);
    idle(5);
    check_val("hold_i", 32'(w_i), 32'd256);
    check_val("hold_sad", w_sad, 32'd65280);
    check_val("hold_cnt1", 32'(w_count1), 32'd1);
    check_val("hold_cnt2", 32'(w_count2), 32'd1);

    // ramp on stream 1
    do_reset("rst3");
    for (int k = 0; k < 256; k++) begin
      drive(8'(k), 8'h00, 1'b1, 1'b1);
    end
    idle(1);
    wait_count("ramp1", 256);
    idle(2);
    check_val("ramp1_sad", w_sad, 32'd32640);

    // ramp on stream 2
    do_reset("rst4");
    for (int k = 0; k < 256; k++) begin
      drive(8'h00, 8'(k), 1'b1, 1'b1);
    end
    idle(1);
    wait_count("ramp2", 256);
    idle(2);
    check_val("ramp2_sad", w_sad, 32'd32640);

    // fill FIFO 1 past full, then supply stream 2
    do_reset("rst5");
    for (int k = 0; k < 256; k++) begin
      drive(8'(k), 8'h00, 1'b1, 1'b0);
    end
    drive(8'hAA, 8'h00, 1'b1, 1'b0);
    idle(1);
    check_val("full_cnt1", 32'(w_count1), 32'd256);
    check_val("full_flag1", 32'(w_full1), 32'd1);
    check_val("full_empty2", 32'(w_empty2), 32'd1);
    check_val("full_i", 32'(w_i), 32'd0);
    check_val("full_sad", w_sad, 32'd0);
    for (int k = 0; k < 256; k++) begin
      drive(8'h00, 8'(255 - k), 1'b0, 1'b1);
    end
    idle(1);
    wait_count("full", 256);
    idle(2);
    check_val("full_sadres", w_sad, 32'd32768);
    check_val("full_cnt1_end", 32'(w_count1), 32'd0);
    check_val("full_cnt2_end", 32'(w_count2), 32'd0);
    check_val("full_dout1", 32'(w_dout1), 32'd255);
    check_val("full_dout2", 32'(w_dout2), 32'd0);

    // reset mid-block, then restart with maximum-difference data
    do_reset("rst6");
    for (int k = 0; k < 100; k++) begin
      drive(8'hFF, 8'h00, 1'b1, 1'b1);
    end
    idle(1);
    wait_count("mid", 100);
    check_val("mid_sad", w_sad, 32'd25500);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 256; k++) begin
      drive(8'hFF, 8'h00, 1'b1, 1'b1);
    end
    idle(1);
    wait_count("restart", 256);
    idle(2);
    check_val("restart_sad", w_sad, 32'd65280);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
